phase_bank_loader: RTL
======================

Name: phase_bank_loader

Overview:
- Parametrised successor to the per-channel phase parser. Accepts addressed phase words over a valid/ready stream and writes them into a shadow bank.
- Copies the whole shadow bank to the active bank on frame commit, so all transducer channels change phase at once.
- Commit can be held until an external period-boundary strobe, so the emitters never see a half-updated frame.
- Sits between the host/UART word deframer and the per-channel phase generators.

Parameters:
- NUM_CHANNELS, 256, number of transducer channels (>=2).
- PHASE_W, 8, bits per phase value.
- ADDR_W, $clog2(NUM_CHANNELS), channel address width. Must be >= 1.
- SYNC_COMMIT, 1. 1 = commit waits for sync_strobe. 0 = commit immediately on the last word.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  word valid.
- in_ready  out  1  block can accept a word.
- in_addr  in  ADDR_W  target channel. Ignored when in_bcast=1.
- in_phase  in  PHASE_W  phase value.
- in_bcast  in  1  write in_phase to every shadow entry.
- in_last  in  1  last word of frame; requests commit.
- sync_strobe  in  1  single-cycle carrier-period boundary pulse.
- err_clr  in  1  clears err_addr.
- phases  out  [NUM_CHANNELS][PHASE_W]  active bank, registered.
- frame_count  out  16  committed-frame counter; wraps at 0xFFFF->0.
- commit_pulse  out  1  high for one cycle, on the cycle after the active bank updates.
- err_addr  out  1  sticky: an out-of-range address was accepted.

Behaviour:
- Reset (async assert, sync release): shadow and active banks all 0, frame_count=0, commit_pulse=0, err_addr=0, state=ACCEPT. in_ready=0 while rst_n=0.
- accept = in_valid & in_ready. Data is sampled only on accept. in_valid may stay high across in_ready=0; the word is held, not lost.
- Accepted word, in_bcast=0, in_addr<NUM_CHANNELS: shadow[in_addr]<=in_phase.
- Accepted word, in_bcast=0, in_addr>=NUM_CHANNELS: no write, err_addr<=1. This applies only when NUM_CHANNELS is not a power of 2.
- Accepted word, in_bcast=1: every shadow entry <= in_phase in one cycle; in_addr is not checked.
- err_clr clears err_addr. If a new error and err_clr occur in the same cycle, set wins.
- FSM states are ACCEPT and PENDING.
- ACCEPT:
  - in_ready=1.
  - Accepted in_last with SYNC_COMMIT=0: active <= shadow merged with the current word's write, at the same edge. frame_count+1, commit_pulse=1 on the next cycle. Stay in ACCEPT, so back-to-back single-word frames run at one per cycle.
  - Accepted in_last with SYNC_COMMIT=1: write the shadow, go to PENDING.
- PENDING:
  - in_ready=0.
  - On sync_strobe=1: active <= shadow, frame_count+1, commit_pulse next cycle, return to ACCEPT.
  - A sync_strobe in the same cycle as the accepted in_last is ignored; only a strobe in PENDING commits.
- Latency:
  - phases update at the commit edge and are stable from that edge on.
  - Non-last words are never visible on phases before a commit.
- Bcast and in_last together: the fill and the commit both apply. The active bank receives the broadcast value.
- Reset mid-PENDING or mid-frame: discard the partial frame, clear both banks, return to ACCEPT.
- A frame with an erroneous address still commits on in_last; its valid entries are applied.

Decomposition:
- Package phase_pkg holds:
  - PHASE_W default;
  - typedef phase_t (logic [PHASE_W-1:0]);
  - enum loader_state_t {ACCEPT, PENDING};
  - FRAME_CNT_W=16.
- Sub-module phase_bank is natural: a register array with write-one, write-all and a parallel read-out, instantiated twice (shadow and active). The active-bank instance loads from the shadow bank's next value.

Test Plan (NUM_CHANNELS=4, PHASE_W=8):
- Reset check: rst_n low mid-run -> phases all 0x00, frame_count=0, err_addr=0, in_ready=0 during reset and 1 one cycle after release.
- SYNC_COMMIT=0, writes {0:0x11, 1:0x22, 2:0x33, 3:0x44 with last} -> phases stay 0 until the last accept edge, then read {11,22,33,44}. commit_pulse for 1 cycle, frame_count=1.
- SYNC_COMMIT=1, same frame:
  - after last, in_ready=0 and phases unchanged;
  - a strobe in the same cycle as last is ignored;
  - a strobe 5 cycles later -> phases {11,22,33,44} and frame_count=1.
- Bcast 0x7F with last, SYNC_COMMIT=0 -> all four phases 0x7F after 1 edge, frame_count increments.
- Backpressure: in_valid held high while PENDING -> the word is accepted the cycle after the strobe commit, not lost and not duplicated.
- Error and counter wrap:
  - NUM_CHANNELS=3 with addr 3 -> err_addr=1, no write;
  - err_clr and a new error in the same cycle -> err_addr stays 1;
  - preload frame_count=0xFFFF, commit -> 0x0000.

Source files
------------

// File: rtl/phase_bank_loader_pkg.sv
// -----------------------------------------------------------------------------
// phase_pkg
// Shared types and constants for the phase bank loader.
//   PHASE_W_DEFAULT : default bits per phase value
//   FRAME_CNT_W     : width of the committed-frame counter
//   phase_t         : one phase value at the default width
//   loader_state_t  : loader FSM states (ACCEPT, PENDING)
// -----------------------------------------------------------------------------
package phase_pkg;

  localparam int PHASE_W_DEFAULT = 8;
  localparam int FRAME_CNT_W     = 16;

  typedef logic [PHASE_W_DEFAULT-1:0] phase_t;

  typedef enum logic {
    ACCEPT  = 1'b0,
    PENDING = 1'b1
  } loader_state_t;

endpackage

// File: rtl/phase_bank_loader_bank.sv
// -----------------------------------------------------------------------------
// phase_bank
// Register array of N phase entries with a single-entry write, a write-all
// (broadcast) and an optional whole-bank load.  When loading, the write port
// is applied on top of the loaded data, so a bank can capture another bank's
// contents merged with a word arriving on the same edge.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset (clears all entries)
//   i_wr_en       : write i_wr_data to entry i_wr_addr
//   i_wr_addr     : entry index for i_wr_en
//   i_wr_all      : write i_wr_data to every entry
//   i_wr_data     : write data
//   i_load_en     : replace the bank with i_load_data (writes still merged)
//   i_load_data   : data to load
//   o_bank        : registered bank contents
// -----------------------------------------------------------------------------
module phase_bank #(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int AW = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_wr_en,
  input  logic [AW-1:0]       i_wr_addr,
  input  logic                i_wr_all,
  input  logic [W-1:0]        i_wr_data,
  input  logic                i_load_en,
  input  logic [N-1:0][W-1:0] i_load_data,
  output logic [N-1:0][W-1:0] o_bank
);

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_entry
      logic [W-1:0] r_q;
      logic [W-1:0] w_base;
      logic         w_hit;

      assign w_base = i_load_en ? i_load_data[gi] : r_q;
      assign w_hit  = i_wr_all || (i_wr_en && (i_wr_addr == AW'(gi)));

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_q <= '0;
        end else begin
          r_q <= w_hit ? i_wr_data : w_base;
        end
      end

      assign o_bank[gi] = r_q;
    end
  endgenerate

endmodule

// File: rtl/phase_bank_loader.sv
// -----------------------------------------------------------------------------
// phase_bank_loader
// Accepts addressed phase words on a valid/ready stream into a shadow bank and
// copies the whole bank to the active bank on frame commit, so all channels
// change phase together.  With SYNC_COMMIT=1 the commit waits for the
// carrier-period strobe; with SYNC_COMMIT=0 it happens on the last word.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   in_valid      : word valid
//   in_ready      : block can accept a word
//   in_addr       : target channel (ignored on broadcast)
//   in_phase      : phase value
//   in_bcast      : write in_phase to every shadow entry
//   in_last       : last word of frame, requests commit
//   sync_strobe   : single-cycle period boundary pulse
//   err_clr       : clears err_addr
//   phases        : active bank, registered
//   frame_count   : committed-frame counter, wraps
//   commit_pulse  : one cycle high on the cycle after the active bank updates
//   err_addr      : sticky out-of-range address flag
// -----------------------------------------------------------------------------
module phase_bank_loader
  import phase_pkg::*;
#(
  parameter int NUM_CHANNELS = 256,
  parameter int PHASE_W      = PHASE_W_DEFAULT,
  parameter int ADDR_W       = $clog2(NUM_CHANNELS),
  parameter int SYNC_COMMIT  = 1
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [ADDR_W-1:0]                  in_addr,
  input  logic [PHASE_W-1:0]                 in_phase,
  input  logic                               in_bcast,
  input  logic                               in_last,
  input  logic                               sync_strobe,
  input  logic                               err_clr,
  output logic [NUM_CHANNELS-1:0][PHASE_W-1:0] phases,
  output logic [FRAME_CNT_W-1:0]             frame_count,
  output logic                               commit_pulse,
  output logic                               err_addr
);

  // One extra bit so NUM_CHANNELS itself is representable for the range check.
  localparam logic [ADDR_W:0]          NUM_L   = (ADDR_W+1)'(NUM_CHANNELS);
  localparam logic [FRAME_CNT_W-1:0]   CNT_ONE = FRAME_CNT_W'(1);
  localparam bit                       SYNC    = (SYNC_COMMIT != 0);

  loader_state_t                       r_state;
  logic                                r_ready;
  logic [FRAME_CNT_W-1:0]              r_frame_count;
  logic                                r_commit_pulse;
  logic                                r_err_addr;

  logic                                w_accept;
  logic                                w_in_range;
  logic                                w_wr_one;
  logic                                w_wr_all;
  logic                                w_err_set;
  logic                                w_commit;
  logic [NUM_CHANNELS-1:0][PHASE_W-1:0] w_shadow;

  assign w_accept   = in_valid && r_ready;
  assign w_in_range = ({1'b0, in_addr} < NUM_L);
  assign w_wr_one   = w_accept && !in_bcast && w_in_range;
  assign w_wr_all   = w_accept && in_bcast;
  assign w_err_set  = w_accept && !in_bcast && !w_in_range;

  // Immediate commit on the last word, or deferred commit on the strobe.
  // A strobe coinciding with the last word finds the FSM still in ACCEPT and
  // is therefore ignored.
  assign w_commit = ((r_state == ACCEPT) && w_accept && in_last && !SYNC) ||
                    ((r_state == PENDING) && sync_strobe);

  phase_bank #(
    .N  (NUM_CHANNELS),
    .W  (PHASE_W),
    .AW (ADDR_W)
  ) u_shadow (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_wr_en     (w_wr_one),
    .i_wr_addr   (in_addr),
    .i_wr_all    (w_wr_all),
    .i_wr_data   (in_phase),
    .i_load_en   (1'b0),
    .i_load_data ('0),
    .o_bank      (w_shadow)
  );

  // The active bank loads the shadow bank with the same-edge word merged in,
  // which equals the shadow bank's next value.
  phase_bank #(
    .N  (NUM_CHANNELS),
    .W  (PHASE_W),
    .AW (ADDR_W)
  ) u_active (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_wr_en     (w_wr_one && w_commit),
    .i_wr_addr   (in_addr),
    .i_wr_all    (w_wr_all && w_commit),
    .i_wr_data   (in_phase),
    .i_load_en   (w_commit),
    .i_load_data (w_shadow),
    .o_bank      (phases)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ACCEPT;
      r_ready        <= 1'b0;
      r_frame_count  <= '0;
      r_commit_pulse <= 1'b0;
      r_err_addr     <= 1'b0;
    end else begin
      r_commit_pulse <= w_commit;
      if (w_commit) begin
        r_frame_count <= r_frame_count + CNT_ONE;
      end
      // A new error wins over a simultaneous clear.
      if (w_err_set) begin
        r_err_addr <= 1'b1;
      end else if (err_clr) begin
        r_err_addr <= 1'b0;
      end
      case (r_state)
        ACCEPT: begin
          if (w_accept && in_last && SYNC) begin
            r_state <= PENDING;
            r_ready <= 1'b0;
          end else begin
            r_ready <= 1'b1;
          end
        end
        PENDING: begin
          if (sync_strobe) begin
            r_state <= ACCEPT;
            r_ready <= 1'b1;
          end
        end
        default: begin
          r_state <= ACCEPT;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready     = r_ready;
  assign frame_count  = r_frame_count;
  assign commit_pulse = r_commit_pulse;
  assign err_addr     = r_err_addr;

endmodule
